// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioning slice: channel states,
// button index map and default timing for a 100 MHz clock.
package btn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    PRESSED,
    HELD,
    DEB_RELEASE
  } btn_state_t;

  // Bit positions inside the {C,R,L,D,U} button vector
  localparam int BTN_U = 0;
  localparam int BTN_D = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;
  localparam int BTN_C = 4;

  localparam int NUM_BTN_DEFAULT         = 5;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;
  localparam int HOLD_CYCLES_DEFAULT     = 100_000_000;
  localparam int CNT_W_DEFAULT           = 27;

endpackage

// File: rtl/btn_channel.sv
// One button channel: two-flop synchroniser, debounce/hold FSM with a shared
// cycle counter, and registered level and strobe outputs.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press_stb,
  output logic release_stb,
  output logic hold_stb
);

  // The FSM acts on the count value before increment, so the last count is limit-1
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0]       sync_ff;
  logic             sync;
  btn_state_t       state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[0], raw};
    end
  end

  assign sync = sync_ff[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      level       <= 1'b0;
      press_stb   <= 1'b0;
      release_stb <= 1'b0;
      hold_stb    <= 1'b0;
    end else begin
      press_stb   <= 1'b0;
      release_stb <= 1'b0;
      hold_stb    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (sync) begin
            state <= DEB_PRESS;
            cnt   <= CNT_ONE;
          end
        end
        DEB_PRESS: begin
          if (!sync) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt >= DEB_LAST) begin
            state     <= PRESSED;
            level     <= 1'b1;
            press_stb <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!sync) begin
            state <= DEB_RELEASE;
            cnt   <= CNT_ONE;
          end else if (cnt >= HOLD_LAST) begin
            state    <= HELD;
            hold_stb <= 1'b1;
            cnt      <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        HELD: begin
          if (!sync) begin
            state <= DEB_RELEASE;
            cnt   <= CNT_ONE;
          end
        end
        // A bounce back to 1 returns to PRESSED, so hold timing restarts and stays eligible
        DEB_RELEASE: begin
          if (sync) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt >= DEB_LAST) begin
            state       <= IDLE;
            level       <= 1'b0;
            release_stb <= 1'b1;
            cnt         <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  strobe_exclusive: assert property (@(posedge clk) disable iff (rst)
    $onehot0({press_stb, release_stb, hold_stb}));

  strobe_single_cycle: assert property (@(posedge clk) disable iff (rst)
    (press_stb || release_stb || hold_stb) |=> !(press_stb || release_stb || hold_stb));

endmodule

// File: rtl/btn_conditioner.sv
// Conditions the raw board push-buttons into clean levels plus press, release
// and long-press strobes; every channel is an independent btn_channel.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int NUM_BTN         = NUM_BTN_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_hold,
  output logic               btn_any
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .CNT_W          (CNT_W)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .raw        (btn_raw[i]),
      .level      (btn_level[i]),
      .press_stb  (btn_press[i]),
      .release_stb(btn_release[i]),
      .hold_stb   (btn_hold[i])
    );
  end

  assign btn_any = |btn_level;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short timing (debounce 4, hold 20);
// strobes are checked by a scoreboard monitor, levels by direct sampling.
module tb_btn_conditioner;
  import btn_pkg::*;

  localparam int NB   = 5;
  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int LAT  = 2 + DEB;

  typedef enum int {K_PRESS, K_RELEASE, K_HOLD} kind_t;

  typedef struct {
    int            cycle;
    logic [NB-1:0] press;
    logic [NB-1:0] rel;
    logic [NB-1:0] hold;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic [NB-1:0] btn_hold;
  logic          btn_any;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t exp_q[$];

  btn_conditioner #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES    (HOLD),
    .CNT_W          (27)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_hold   (btn_hold),
    .btn_any    (btn_any)
  );

  always #5 clk = ~clk;

  // cyc equals the number of the most recent rising edge
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cycle(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic applyStimulus(input int ch, input logic val);
    btn_raw[ch] = val;
  endtask

  // Expected strobes are kept sorted by cycle; same-cycle strobes share one entry
  task automatic push_expected(input int cycle, input kind_t kind, input int ch);
    exp_t e;
    int   idx;
    idx     = -1;
    e.cycle = cycle;
    e.press = '0;
    e.rel   = '0;
    e.hold  = '0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].cycle >= cycle) begin
        idx = i;
        break;
      end
    end
    if (idx >= 0 && exp_q[idx].cycle == cycle) e = exp_q[idx];
    case (kind)
      K_PRESS:   e.press[ch] = 1'b1;
      K_RELEASE: e.rel[ch]   = 1'b1;
      default:   e.hold[ch]  = 1'b1;
    endcase
    if (idx < 0) exp_q.push_back(e);
    else if (exp_q[idx].cycle == cycle) exp_q[idx] = e;
    else exp_q.insert(idx, e);
  endtask

  task automatic checkOutput(input string name, input logic [NB-1:0] lvl_exp);
    checks++;
    if (btn_level !== lvl_exp || btn_any !== (|lvl_exp)) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: level=%b any=%b, expected level=%b any=%b",
               name, cyc, btn_level, btn_any, lvl_exp, |lvl_exp);
    end
  endtask

  // Scoreboard monitor: every strobe seen must match the oldest expected entry
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cycle < cyc) begin
        checks++;
        failures++;
        $display("[TB] FAIL missing_strobe: nothing at cycle %0d, expected press=%b release=%b hold=%b",
                 exp_q[0].cycle, exp_q[0].press, exp_q[0].rel, exp_q[0].hold);
        void'(exp_q.pop_front());
      end
      if ((btn_press | btn_release | btn_hold) != '0) begin
        checks++;
        if (exp_q.size() == 0 || exp_q[0].cycle != cyc) begin
          failures++;
          $display("[TB] FAIL unexpected_strobe at cycle %0d: press=%b release=%b hold=%b, expected none",
                   cyc, btn_press, btn_release, btn_hold);
        end else begin
          e = exp_q.pop_front();
          if (btn_press !== e.press || btn_release !== e.rel || btn_hold !== e.hold) begin
            failures++;
            $display("[TB] FAIL strobe_value at cycle %0d: press=%b release=%b hold=%b, expected press=%b release=%b hold=%b",
                     cyc, btn_press, btn_release, btn_hold, e.press, e.rel, e.hold);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t;
    rst     = 1'b1;
    btn_raw = '0;
    tick(3);
    checkOutput("reset_state", '0);
    rst = 1'b0;
    tick(2);

    // Clean press, hold and release on U
    t = cyc;
    applyStimulus(BTN_U, 1'b1);
    push_expected(t + LAT, K_PRESS, BTN_U);
    push_expected(t + LAT + HOLD, K_HOLD, BTN_U);
    wait_cycle(t + LAT - 1);
    checkOutput("clean_before_press", '0);
    wait_cycle(t + LAT);
    checkOutput("clean_pressed", 5'b00001);
    wait_cycle(t + 40);
    applyStimulus(BTN_U, 1'b0);
    push_expected(t + 40 + LAT, K_RELEASE, BTN_U);
    wait_cycle(t + 40 + LAT - 1);
    checkOutput("clean_before_release", 5'b00001);
    wait_cycle(t + 40 + LAT);
    checkOutput("clean_released", '0);
    tick(4);

    // Bouncing press on R: two-cycle pulses, then steady high
    t = cyc;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(BTN_R, (i % 2 == 0) ? 1'b1 : 1'b0);
      tick(2);
    end
    applyStimulus(BTN_R, 1'b1);
    push_expected(t + 8 + LAT, K_PRESS, BTN_R);
    push_expected(t + 8 + LAT + HOLD, K_HOLD, BTN_R);
    wait_cycle(t + 8 + LAT - 1);
    checkOutput("bounce_before_press", '0);
    wait_cycle(t + 8 + LAT);
    checkOutput("bounce_pressed", 5'b01000);
    wait_cycle(t + 40);
    applyStimulus(BTN_R, 1'b0);
    push_expected(t + 40 + LAT, K_RELEASE, BTN_R);
    wait_cycle(t + 40 + LAT);
    checkOutput("bounce_released", '0);
    tick(4);

    // Three-cycle glitch on C must be ignored
    applyStimulus(BTN_C, 1'b1);
    tick(3);
    applyStimulus(BTN_C, 1'b0);
    tick(12);
    checkOutput("glitch_no_level", '0);

    // Release bounce on D restarts hold timing
    t = cyc;
    applyStimulus(BTN_D, 1'b1);
    push_expected(t + LAT, K_PRESS, BTN_D);
    wait_cycle(t + 15);
    applyStimulus(BTN_D, 1'b0);
    tick(2);
    applyStimulus(BTN_D, 1'b1);
    push_expected(t + 15 + 5 + HOLD, K_HOLD, BTN_D);
    wait_cycle(t + 21);
    checkOutput("release_bounce_level", 5'b00010);
    wait_cycle(t + 50);
    applyStimulus(BTN_D, 1'b0);
    push_expected(t + 50 + LAT, K_RELEASE, BTN_D);
    wait_cycle(t + 50 + LAT);
    checkOutput("release_bounce_released", '0);
    tick(4);

    // Simultaneous U and D
    t = cyc;
    applyStimulus(BTN_U, 1'b1);
    applyStimulus(BTN_D, 1'b1);
    push_expected(t + LAT, K_PRESS, BTN_U);
    push_expected(t + LAT, K_PRESS, BTN_D);
    wait_cycle(t + LAT);
    checkOutput("simultaneous_pressed", 5'b00011);
    wait_cycle(t + 10);
    applyStimulus(BTN_U, 1'b0);
    applyStimulus(BTN_D, 1'b0);
    push_expected(t + 10 + LAT, K_RELEASE, BTN_U);
    push_expected(t + 10 + LAT, K_RELEASE, BTN_D);
    wait_cycle(t + 10 + LAT);
    checkOutput("simultaneous_released", '0);
    tick(4);

    // Reset during DEB_PRESS, then during PRESSED, with L held throughout
    t = cyc;
    applyStimulus(BTN_L, 1'b1);
    wait_cycle(t + 4);
    rst = 1'b1;
    tick(1);
    checkOutput("reset_mid_debounce", '0);
    rst = 1'b0;
    push_expected(t + 5 + LAT, K_PRESS, BTN_L);
    wait_cycle(t + 5 + LAT - 1);
    checkOutput("reset_debounce_before_press", '0);
    wait_cycle(t + 5 + LAT);
    checkOutput("reset_debounce_pressed", 5'b00100);
    wait_cycle(t + 15);
    rst = 1'b1;
    tick(1);
    checkOutput("reset_mid_pressed", '0);
    rst = 1'b0;
    push_expected(t + 16 + LAT, K_PRESS, BTN_L);
    wait_cycle(t + 16 + LAT);
    checkOutput("reset_pressed_repress", 5'b00100);
    wait_cycle(t + 30);
    applyStimulus(BTN_L, 1'b0);
    push_expected(t + 30 + LAT, K_RELEASE, BTN_L);
    wait_cycle(t + 30 + LAT);
    checkOutput("reset_final_release", '0);
    tick(10);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL pending_strobes: %0d expected strobes never seen, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
